// File: rtl/vec_mem_responder.sv
// Word-addressed memory model answering vec_lsu loads/stores with fixed latency.
// Latency: strobe arrives LATENCY cycles after the accepting edge.
// Backpressure: one request outstanding; requests arriving while mem_busy is high are dropped.
module vec_mem_responder #(
    parameter int MEM_DATA_WIDTH = 32,
    parameter int DEPTH          = 1024,
    parameter int LATENCY        = 3,
    parameter int XLEN           = 32
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        ld_req,
    input  logic                        st_req,
    input  logic [XLEN-1:0]             lsu2mem_addr,
    input  logic [MEM_DATA_WIDTH-1:0]   lsu2mem_data,
    input  logic [MEM_DATA_WIDTH/8-1:0] lsu2mem_wmask,
    output logic [MEM_DATA_WIDTH-1:0]   mem2lsu_data,
    output logic                        mem_ld_valid,
    output logic                        mem_st_done,
    output logic                        mem_busy,
    output logic                        mem_err
);
    localparam int NB   = MEM_DATA_WIDTH / 8;
    localparam int OFF  = $clog2(NB);
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    logic [XLEN-1:0]           lat_addr;
    logic [MEM_DATA_WIDTH-1:0] lat_data;
    logic [NB-1:0]             lat_mask;
    logic                      lat_ld;
    logic                      lat_st;

    logic [MEM_DATA_WIDTH-1:0] mem [DEPTH];

    logic            accept;
    logic [XLEN-1:0] word_idx;
    logic [IDXW-1:0] mem_idx;
    logic            resp_err;
    logic            do_rd;
    logic            do_wr;

    assign accept   = (state == IDLE) && (ld_req || st_req);
    assign mem_busy = (state != IDLE);

    // Everything below works from the latched request so input wiggles during WAIT are harmless.
    assign word_idx = lat_addr >> OFF;
    assign mem_idx  = word_idx[IDXW-1:0];
    assign resp_err = ((lat_addr & XLEN'(NB - 1)) != '0) ||
                      (word_idx >= XLEN'(DEPTH)) ||
                      (lat_ld && lat_st);
    assign do_rd    = (state == RESP) && !resp_err && lat_ld;
    assign do_wr    = (state == RESP) && !resp_err && lat_st;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_mask <= '0;
            lat_ld   <= 1'b0;
            lat_st   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                lat_addr <= lsu2mem_addr;
                lat_data <= lsu2mem_data;
                lat_mask <= lsu2mem_wmask;
                lat_ld   <= ld_req;
                lat_st   <= st_req;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) begin
                    cnt_nxt   = '0;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are registered so the store commits on the same edge that raises mem_st_done.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem2lsu_data <= '0;
            mem_ld_valid <= 1'b0;
            mem_st_done  <= 1'b0;
            mem_err      <= 1'b0;
        end else begin
            mem_ld_valid <= do_rd;
            mem_st_done  <= do_wr;
            mem_err      <= (state == RESP) && resp_err;
            if (do_rd) begin
                mem2lsu_data <= mem[mem_idx];
            end else if ((state == RESP) && resp_err && lat_ld && !lat_st) begin
                mem2lsu_data <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (lat_mask[b]) begin
                    mem[mem_idx][8*b +: 8] <= lat_data[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_vec_mem_responder.sv
// Directed bench for vec_mem_responder: driver queues expected responses, negedge monitor checks them.
module tb_vec_mem_responder;
    localparam int LAT = 3;
    localparam int K_LD = 0;
    localparam int K_ST = 1;
    localparam int K_ER = 2;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        ld_req = 1'b0;
    logic        st_req = 1'b0;
    logic [31:0] lsu2mem_addr = '0;
    logic [31:0] lsu2mem_data = '0;
    logic [3:0]  lsu2mem_wmask = '0;
    logic [31:0] mem2lsu_data;
    logic        mem_ld_valid;
    logic        mem_st_done;
    logic        mem_busy;
    logic        mem_err;

    vec_mem_responder #(
        .MEM_DATA_WIDTH(32), .DEPTH(1024), .LATENCY(LAT), .XLEN(32)
    ) dut (
        .clk(clk), .n_rst(n_rst),
        .ld_req(ld_req), .st_req(st_req),
        .lsu2mem_addr(lsu2mem_addr), .lsu2mem_data(lsu2mem_data),
        .lsu2mem_wmask(lsu2mem_wmask),
        .mem2lsu_data(mem2lsu_data), .mem_ld_valid(mem_ld_valid),
        .mem_st_done(mem_st_done), .mem_busy(mem_busy), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] data;
        bit          chk_data;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (n_rst && (mem_ld_valid || mem_st_done || mem_err)) begin
            int   k;
            exp_t e;
            k = mem_err ? K_ER : (mem_st_done ? K_ST : K_LD);
            chk("strobe_onehot", 32'($countones({mem_ld_valid, mem_st_done, mem_err})), 32'd1);
            if (q.size() == 0) begin
                chk("unexpected_strobe_kind", 32'(k), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("resp_kind", 32'(k), 32'(e.kind));
                chk("resp_latency", 32'(cyc - e.acc), 32'(LAT));
                if (e.chk_data) chk("resp_data", mem2lsu_data, e.data);
            end
        end
    end

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic issue(input logic ld, input logic st, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        ld_req = ld; st_req = st;
        lsu2mem_addr = a; lsu2mem_data = d; lsu2mem_wmask = m;
    endtask

    task automatic do_req(input logic ld, input logic st, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m,
                          input int kind, input logic [31:0] ed, input bit cd);
        issue(ld, st, a, d, m);
        q.push_back('{kind: kind, data: ed, chk_data: cd, acc: cyc + 1});
        @(negedge clk);
        ld_req = 1'b0; st_req = 1'b0;
        lsu2mem_data = 32'hBAD0_BAD0;
        drain();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_data"},  mem2lsu_data, 32'd0);
        chk({tag, "_ldv"},   32'(mem_ld_valid), 32'd0);
        chk({tag, "_std"},   32'(mem_st_done), 32'd0);
        chk({tag, "_busy"},  32'(mem_busy), 32'd0);
        chk({tag, "_err"},   32'(mem_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        n_rst = 1'b1;

        do_req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, K_ST, 32'h0, 1);
        do_req(1, 0, 32'h10, 32'h0,        4'h0, K_LD, 32'hDEADBEEF, 1);
        do_req(0, 1, 32'h10, 32'h12345678, 4'h3, K_ST, 32'hDEADBEEF, 1);
        do_req(1, 0, 32'h10, 32'h0,        4'h0, K_LD, 32'hDEAD5678, 1);
        do_req(1, 0, 32'h11, 32'h0,        4'h0, K_ER, 32'h0, 1);
        do_req(1, 0, 32'h10, 32'h0,        4'h0, K_LD, 32'hDEAD5678, 1);
        do_req(1, 0, 32'h1000, 32'h0,      4'h0, K_ER, 32'h0, 1);
        do_req(0, 1, 32'h20, 32'hCAFEF00D, 4'hF, K_ST, 32'h0, 1);
        do_req(1, 1, 32'h20, 32'h0BADBAD0, 4'hF, K_ER, 32'h0, 0);
        do_req(1, 0, 32'h20, 32'h0,        4'h0, K_LD, 32'hCAFEF00D, 1);

        // A second load pulsed during WAIT must be dropped.
        issue(1, 0, 32'h10, 32'h0, 4'h0);
        q.push_back('{kind: K_LD, data: 32'hDEAD5678, chk_data: 1, acc: cyc + 1});
        @(negedge clk);
        ld_req = 1'b0;
        chk("busy_in_wait", 32'(mem_busy), 32'd1);
        @(negedge clk);
        ld_req = 1'b1; lsu2mem_addr = 32'h20;
        @(negedge clk);
        ld_req = 1'b0;
        drain();
        repeat (8) @(negedge clk);
        chk("busy_idle", 32'(mem_busy), 32'd0);

        do_req(0, 1, 32'h40, 32'hFFFFFFFF, 4'hF, K_ST, 32'hDEAD5678, 1);
        do_req(0, 1, 32'h40, 32'h00000000, 4'h9, K_ST, 32'hDEAD5678, 1);
        do_req(1, 0, 32'h40, 32'h0,        4'h0, K_LD, 32'h00FFFF00, 1);
        do_req(0, 1, 32'hFFC, 32'h5A5A5A5A, 4'hF, K_ST, 32'h00FFFF00, 1);
        do_req(1, 0, 32'hFFC, 32'h0,        4'h0, K_LD, 32'h5A5A5A5A, 1);
        do_req(0, 1, 32'h30, 32'h11223344, 4'hF, K_ST, 32'h5A5A5A5A, 1);

        // Reset during WAIT of a store: aborted, outputs cleared, memory untouched.
        issue(0, 1, 32'h30, 32'hA5A5A5A5, 4'hF);
        @(negedge clk);
        st_req = 1'b0;
        chk("busy_before_rst", 32'(mem_busy), 32'd1);
        #2 n_rst = 1'b0;
        #1 check_all_zero("midrst");
        @(negedge clk);
        n_rst = 1'b1;
        repeat (6) @(negedge clk);
        check_all_zero("postrst");
        do_req(1, 0, 32'h30, 32'h0, 4'h0, K_LD, 32'h11223344, 1);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
